// File: rtl/cell_mem_arbiter_pkg.sv
// Shared types for the cell memory arbiter: phase encoding, FSM states, starve counter width.
package cell_arb_pkg;
  typedef enum logic {PHASE_FORCE = 1'b0, PHASE_MOTION = 1'b1} phase_t;
  typedef enum logic [1:0] {ST_FORCE = 2'd0, ST_DRAIN = 2'd1, ST_MOTION = 2'd2} arb_state_t;

  localparam int STARVE_W = 4;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/cell_mem_arbiter_if.sv
// Requester, phase and memory-side signals of the cell memory arbiter.
interface cell_mem_arbiter_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  phase_req;
  logic                  phase_cur;
  logic                  phase_ack;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  addr_err;

  modport master (
    output phase_req, rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_q,
    input  phase_cur, phase_ack, rd_gnt, rd_data_valid, rd_data, wr_gnt,
           mem_address, mem_data, mem_rden, mem_wren, addr_err
  );

  modport slave (
    input  phase_req, rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_q,
    output phase_cur, phase_ack, rd_gnt, rd_data_valid, rd_data, wr_gnt,
           mem_address, mem_data, mem_rden, mem_wren, addr_err
  );
endinterface

// File: rtl/cell_mem_arbiter_rd_pipe.sv
// Read-return alignment: RD_LATENCY-deep valid/zero-force shift register matching mem_q timing.
module cell_arb_rd_pipe #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  input  logic i_zero,
  output logic o_vld,
  output logic o_zero,
  output logic o_busy
);
  logic [RD_LATENCY-1:0] r_vld;
  logic [RD_LATENCY-1:0] r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_zero <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_zero[0] <= i_zero;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_zero[i] <= r_zero[i-1];
      end
    end
  end

  assign o_vld  = r_vld[RD_LATENCY-1];
  assign o_zero = r_zero[RD_LATENCY-1];
  assign o_busy = |r_vld;
endmodule

// File: rtl/cell_mem_arbiter.sv
// Shares one single-port cell memory between force-fetch reads and motion writebacks, sequencing the
// FORCE/MOTION phase with drain. Optional grant/conflict statistics under CELL_ARB_STATS_EN.
module cell_mem_arbiter
  import cell_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  cell_mem_arbiter_if.slave bus
`ifdef CELL_ARB_STATS_EN
  ,
  output logic [15:0] stat_rd_cnt,
  output logic [15:0] stat_wr_cnt,
  output logic [15:0] stat_conflict_cnt
`endif
);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_t            r_state;
  phase_t                r_phase_cur;
  logic                  r_phase_ack;
  logic [STARVE_W-1:0]   r_rd_starve, r_wr_starve;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_mem_rden, r_mem_wren;
  logic                  r_rd_pend, r_rd_zero;
  logic                  r_addr_err;

  phase_t w_phase_req;
  logic   w_arb_en, w_both, w_rd_gnt, w_wr_gnt, w_rd_oor, w_wr_oor;
  logic   w_pipe_vld, w_pipe_zero, w_pipe_busy, w_busy;

  assign w_phase_req = phase_t'(bus.phase_req);
  assign w_arb_en    = !rst && (r_state != ST_DRAIN) && (w_phase_req == r_phase_cur);
  assign w_both      = bus.rd_req & bus.wr_req;
  assign w_rd_oor    = 32'(bus.rd_addr) >= 32'(PARTICLE_NUM);
  assign w_wr_oor    = 32'(bus.wr_addr) >= 32'(PARTICLE_NUM);
  // Out-of-range reads still occupy the return path so result order is preserved.
  assign w_busy      = w_pipe_busy | r_rd_pend | r_mem_wren;

  always_comb begin
    w_rd_gnt = 1'b0;
    w_wr_gnt = 1'b0;
    if (w_arb_en) begin
      if (w_both) begin
        if (r_state == ST_FORCE) begin
          if (r_wr_starve == LIMIT) w_wr_gnt = 1'b1;
          else                      w_rd_gnt = 1'b1;
        end else begin
          if (r_rd_starve == LIMIT) w_rd_gnt = 1'b1;
          else                      w_wr_gnt = 1'b1;
        end
      end else begin
        w_rd_gnt = bus.rd_req;
        w_wr_gnt = bus.wr_req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_FORCE;
      r_phase_cur   <= PHASE_FORCE;
      r_phase_ack   <= 1'b0;
      r_rd_starve   <= '0;
      r_wr_starve   <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_rden    <= 1'b0;
      r_mem_wren    <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_rd_zero     <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      r_phase_ack <= 1'b0;
      case (r_state)
        ST_FORCE, ST_MOTION: begin
          if (w_phase_req != r_phase_cur) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_phase_req == r_phase_cur) begin
            r_state <= (r_phase_cur == PHASE_MOTION) ? ST_MOTION : ST_FORCE;
          end else if (!w_busy) begin
            r_phase_cur <= w_phase_req;
            r_state     <= (w_phase_req == PHASE_MOTION) ? ST_MOTION : ST_FORCE;
            r_phase_ack <= 1'b1;
          end
        end
        default: r_state <= ST_FORCE;
      endcase

      if (!bus.rd_req || w_rd_gnt)   r_rd_starve <= '0;
      else if (w_arb_en && w_both)   r_rd_starve <= r_rd_starve + 1'b1;
      if (!bus.wr_req || w_wr_gnt)   r_wr_starve <= '0;
      else if (w_arb_en && w_both)   r_wr_starve <= r_wr_starve + 1'b1;

      r_mem_rden <= w_rd_gnt && !w_rd_oor;
      r_mem_wren <= w_wr_gnt && !w_wr_oor;
      if (w_rd_gnt && !w_rd_oor) begin
        r_mem_address <= bus.rd_addr;
      end else if (w_wr_gnt && !w_wr_oor) begin
        r_mem_address <= bus.wr_addr;
        r_mem_data    <= bus.wr_data;
      end
      r_rd_pend <= w_rd_gnt;
      r_rd_zero <= w_rd_gnt && w_rd_oor;
      if ((w_rd_gnt && w_rd_oor) || (w_wr_gnt && w_wr_oor)) r_addr_err <= 1'b1;
    end
  end

  cell_arb_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (r_rd_pend),
    .i_zero (r_rd_zero),
    .o_vld  (w_pipe_vld),
    .o_zero (w_pipe_zero),
    .o_busy (w_pipe_busy)
  );

  assign bus.phase_cur     = r_phase_cur;
  assign bus.phase_ack     = r_phase_ack;
  assign bus.rd_gnt        = w_rd_gnt;
  assign bus.wr_gnt        = w_wr_gnt;
  assign bus.rd_data_valid = w_pipe_vld;
  assign bus.rd_data       = (w_pipe_vld && !w_pipe_zero) ? bus.mem_q : '0;
  assign bus.mem_address   = r_mem_address;
  assign bus.mem_data      = r_mem_data;
  assign bus.mem_rden      = r_mem_rden;
  assign bus.mem_wren      = r_mem_wren;
  assign bus.addr_err      = r_addr_err;

`ifdef CELL_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_cnt       <= '0;
      stat_wr_cnt       <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (w_rd_gnt)           stat_rd_cnt       <= sat_inc(stat_rd_cnt);
      if (w_wr_gnt)           stat_wr_cnt       <= sat_inc(stat_wr_cnt);
      if (w_arb_en && w_both) stat_conflict_cnt <= sat_inc(stat_conflict_cnt);
    end
  end
`endif
endmodule
